// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared types and helpers for the byte dispatch controller and its
// sub-blocks.
//   state_t    : controller FSM states (IDLE, HOLD)
//   NCH, SELW  : number of output channels and width of the channel select
//   sel2onehot : 2-bit channel select to 4-bit one-hot valid vector
// ---------------------------------------------------------------------------
package demux_pkg;

   localparam int NCH  = 4;
   localparam int SELW = 2;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   function automatic logic [NCH-1:0] sel2onehot(input logic [SELW-1:0] sel);
      logic [NCH-1:0] w_oh;
      w_oh      = '0;
      w_oh[sel] = 1'b1;
      return w_oh;
   endfunction

endpackage

// File: rtl/demux_timeout_cnt.sv
// ---------------------------------------------------------------------------
// demux_timeout_cnt
// 8-bit wait counter with an expire flag, meant to be reused by any channel
// controller that must give up on a stalled consumer.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (counter -> 0)
//   clr    : synchronous clear (wins over en)
//   en     : count this cycle (one more cycle spent waiting)
//   expire : combinational; high while en=1 and the counter sits at
//            TIMEOUT-1, i.e. this edge completes the TIMEOUT-th wait cycle
// Parameter TIMEOUT (0..255): 0 disables the watchdog, the counter then
// stays at 0 and expire never asserts.
// ---------------------------------------------------------------------------
module demux_timeout_cnt #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam bit         LP_ACTIVE = (TIMEOUT != 0);
   localparam logic [7:0] LP_LAST   = LP_ACTIVE ? 8'(TIMEOUT - 1) : 8'd0;

   logic [7:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 8'd0;
      end else if (clr) begin
         r_cnt <= 8'd0;
      end else if (en && LP_ACTIVE) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign expire = LP_ACTIVE && en && (r_cnt == LP_LAST);

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// demux_dispatch_ctrl
// Single-entry dispatch controller sequencing a 1-to-4 byte demultiplexer.
// A byte plus destination is accepted from upstream, held, and offered to
// exactly one output channel. A watchdog drops the byte if the selected
// channel stays not-ready for TIMEOUT HOLD cycles.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready of the same interface, and a
// holder keeps data stable until its transfer (or a watchdog drop).
//
// Ports:
//   clk, rst        : clock (rising) and asynchronous active-high reset
//   in_data/in_dest : byte and channel offered upstream, qualified by in_valid
//   in_valid        : upstream offers a byte
//   in_ready        : high in IDLE; the controller takes one byte
//   out_data        : held byte, shared by all channels
//   out_sel         : demux select = held destination
//   out_valid[3:0]  : one-hot valid towards the selected channel
//   out_ready[3:0]  : per-channel ready; only the selected bit is looked at
//   busy            : high while a byte is held (FSM state == HOLD, doubles
//                     as the state debug view)
//   drop_pulse      : registered one-cycle pulse after a watchdog drop
// Optional (macro DEMUX_DISPATCH_STATS_EN):
//   stat_cnt[31:0]  : four 8-bit saturating delivery counters, ch n at [8n+7:8n]
//   drop_cnt[7:0]   : saturating count of drop_pulse events
// ---------------------------------------------------------------------------
module demux_dispatch_ctrl
   import demux_pkg::*;
#(
   parameter int DW      = 8,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   in_data,
   input  logic [SELW-1:0] in_dest,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [DW-1:0]   out_data,
   output logic [SELW-1:0] out_sel,
   output logic [NCH-1:0]  out_valid,
   input  logic [NCH-1:0]  out_ready,
   output logic            busy,
`ifdef DEMUX_DISPATCH_STATS_EN
   output logic [31:0]     stat_cnt,
   output logic [7:0]      drop_cnt,
`endif
   output logic            drop_pulse
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [DW-1:0]   r_data;
   logic [SELW-1:0] r_sel;
   logic            r_drop;

   logic            w_accept;
   logic            w_ready_sel;
   logic            w_deliver;
   logic            w_expire;

   assign w_accept    = (r_state == IDLE) && in_valid;
   assign w_ready_sel = out_ready[r_sel];
   assign w_deliver   = (r_state == HOLD) && w_ready_sel;

   // en excludes the delivery cycle, so expire can only fire when the
   // selected channel is not ready: delivery always wins a tie.
   demux_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_accept),
      .en     ((r_state == HOLD) && !w_ready_sel),
      .expire (w_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = HOLD;
         HOLD:    if (w_deliver || w_expire) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
         r_sel  <= '0;
         r_drop <= 1'b0;
      end else begin
         if (w_accept) begin
            r_data <= in_data;
            r_sel  <= in_dest;
         end
         // expire implies HOLD -> IDLE, so this can never be high twice in a row
         r_drop <= w_expire;
      end
   end

   assign in_ready   = (r_state == IDLE);
   assign busy       = (r_state == HOLD);
   assign out_data   = r_data;
   assign out_sel    = r_sel;
   assign out_valid  = (r_state == HOLD) ? sel2onehot(r_sel) : '0;
   assign drop_pulse = r_drop;

`ifdef DEMUX_DISPATCH_STATS_EN
   logic [NCH-1:0][7:0] r_stat;
   logic [7:0]          r_drop_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat     <= '0;
         r_drop_cnt <= 8'd0;
      end else begin
         if (w_deliver && (r_stat[r_sel] != 8'hFF)) begin
            r_stat[r_sel] <= r_stat[r_sel] + 8'd1;
         end
         if (r_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   assign stat_cnt = r_stat;
   assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_demux_dispatch_ctrl
// Directed bench for demux_dispatch_ctrl (DW=8, TIMEOUT=15). Inputs are
// driven 1 time unit after each rising edge; outputs are sampled there too,
// away from the active edge. Compile with +define+DEMUX_DISPATCH_STATS_EN to
// include the statistics counters and their test.
// ---------------------------------------------------------------------------
module tb_demux_dispatch_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic [1:0] in_dest;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic [1:0] out_sel;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic       busy;
   logic       drop_pulse;
`ifdef DEMUX_DISPATCH_STATS_EN
   logic [31:0] stat_cnt;
   logic [7:0]  drop_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   // ---- clock / reset ----
   initial clk = 1'b0;
   always #5 clk = ~clk;

   demux_dispatch_ctrl #(
      .DW      (8),
      .TIMEOUT (15)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_dest    (in_dest),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_sel    (out_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
`ifdef DEMUX_DISPATCH_STATS_EN
      .stat_cnt   (stat_cnt),
      .drop_cnt   (drop_cnt),
`endif
      .drop_pulse (drop_pulse)
   );

   // ---- driver helpers ----
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offer one byte while the bench is in IDLE; returns after the accept edge.
   task automatic send(input logic [7:0] d, input logic [1:0] dst);
      in_data  = d;
      in_dest  = dst;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] t_data [3];
      logic [1:0] t_dest [3];
      logic [3:0] t_oh   [3];
      t_data = '{8'h66, 8'h5A, 8'hC3};
      t_dest = '{2'd3, 2'd1, 2'd2};
      t_oh   = '{4'b1000, 4'b0010, 4'b0100};

      rst       = 1'b1;
      in_data   = 8'h00;
      in_dest   = 2'd0;
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      step();
      step();

      // ---- reset state ----
      chk("rst_in_ready",  32'(in_ready),   32'd1);
      chk("rst_out_valid", 32'(out_valid),  32'd0);
      chk("rst_busy",      32'(busy),       32'd0);
      chk("rst_drop",      32'(drop_pulse), 32'd0);
      chk("rst_out_data",  32'(out_data),   32'd0);
      chk("rst_out_sel",   32'(out_sel),    32'd0);
      rst = 1'b0;
      step();

      // ---- single byte to channel 0 ----
      out_ready = 4'b0001;
      send(8'h66, 2'd0);
      chk("t1_out_valid", 32'(out_valid), 32'b0001);
      chk("t1_out_sel",   32'(out_sel),   32'd0);
      chk("t1_out_data",  32'(out_data),  32'h66);
      chk("t1_in_ready",  32'(in_ready),  32'd0);
      chk("t1_busy",      32'(busy),      32'd1);
      step();
      chk("t1_idle_in_ready",  32'(in_ready),  32'd1);
      chk("t1_idle_out_valid", 32'(out_valid), 32'd0);

      // ---- back-to-back dest 3,1,2, all ready; in_valid held high ----
      out_ready = 4'b1111;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = t_data[i];
         in_dest = t_dest[i];
         step();
         chk($sformatf("t2_valid_%0d", i), 32'(out_valid), 32'(t_oh[i]));
         chk($sformatf("t2_data_%0d", i),  32'(out_data),  32'(t_data[i]));
         chk($sformatf("t2_inrdy_%0d", i), 32'(in_ready),  32'd0);
         // present junk during HOLD: it must be ignored
         in_data = 8'hEE;
         in_dest = 2'd0;
         step();
         chk($sformatf("t2_idle_%0d", i), 32'(out_valid), 32'd0);
         chk($sformatf("t2_keep_%0d", i), 32'(out_data),  32'(t_data[i]));
      end
      in_valid = 1'b0;
      step();

      // ---- channel 2 stalled: watchdog drop after 15 HOLD cycles ----
      out_ready = 4'b1011;
      send(8'h3C, 2'd2);
      for (int k = 1; k <= 15; k++) begin
         chk($sformatf("t3_hold_%0d", k), 32'({out_valid, drop_pulse}), 32'b01000);
         step();
      end
      chk("t3_drop_pulse", 32'(drop_pulse), 32'd1);
      chk("t3_drop_valid", 32'(out_valid),  32'd0);
      chk("t3_drop_inrdy", 32'(in_ready),   32'd1);
      step();
      chk("t3_drop_once",  32'(drop_pulse), 32'd0);
      chk("t3_stay_idle",  32'(busy),       32'd0);
      step();

      // ---- ready arrives in the 15th HOLD cycle: delivery wins ----
      out_ready = 4'b1011;
      send(8'h99, 2'd2);
      for (int k = 1; k < 15; k++) step();
      chk("t4_hold15_valid", 32'(out_valid), 32'b0100);
      out_ready = 4'b0100;
      step();
      chk("t4_no_drop",   32'(drop_pulse), 32'd0);
      chk("t4_delivered", 32'(out_valid),  32'd0);
      chk("t4_inrdy",     32'(in_ready),   32'd1);
      step();
      chk("t4_no_drop_late", 32'(drop_pulse), 32'd0);

      // ---- async reset mid-HOLD ----
      out_ready = 4'b0000;
      send(8'hA5, 2'd1);
      chk("t5_pre_valid", 32'(out_valid), 32'b0010);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_valid", 32'(out_valid), 32'd0);
      chk("t5_rst_busy",  32'(busy),      32'd0);
      chk("t5_rst_inrdy", 32'(in_ready),  32'd1);
      chk("t5_rst_data",  32'(out_data),  32'd0);
      step();
      rst = 1'b0;
      out_ready = 4'b1111;
      step();
      chk("t5_post_valid", 32'(out_valid), 32'd0);
      step();
      chk("t5_post_busy",  32'(busy),      32'd0);

`ifdef DEMUX_DISPATCH_STATS_EN
      // ---- statistics: 300 deliveries to ch1, one drop ----
      out_ready = 4'b0010;
      for (int n = 0; n < 300; n++) begin
         send(8'(n), 2'd1);
         step();
      end
      out_ready = 4'b0000;
      send(8'h77, 2'd2);
      for (int k = 0; k < 17; k++) step();
      chk("t6_stat_cnt", stat_cnt,        32'h0000_FF00);
      chk("t6_drop_cnt", 32'(drop_cnt),   32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
